avmm_block_read_master: RTL and testbench



---
 rtl/avmm_block_read_master_pkg.sv | 14 +
 rtl/avmm_block_read_master_sync_fifo.sv | 55 +++++
 rtl/avmm_block_read_master.sv | 174 +++++++++++++++++
 tb/tb_avmm_block_read_master.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_block_read_master_pkg.sv
// Shared types and constants for the Avalon-MM block read master.
package avmm_block_read_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;
    localparam int DEFAULT_READ_LATENCY = 1;

endpackage

// File: rtl/avmm_block_read_master_sync_fifo.sv
// Synchronous FIFO holding returned read words; DEPTH must be a power of 2.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    // A push into a full FIFO is accepted only when a pop frees a slot
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/avmm_block_read_master.sv
// Avalon-MM block read master streaming words out through a credit-managed FIFO.
// Optional running checksum of popped words: define AVMM_READ_CHECKSUM_EN.
module avmm_block_read_master
    import avmm_block_read_master_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 16,
    parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic              m_clken,
    input  logic [DATA_W-1:0] m_readdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [DATA_W-1:0] checksum
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                  state;
    logic [ADDR_W-1:0]       base_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W:0]          len_ext;
    logic [LEN_W:0]          issued;
    logic [LEN_W:0]          popped;
    logic [LEN_W:0]          rcvd;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic [31:0]             occupancy;
    logic                    can_issue;
    logic                    push;
    logic                    push_last;
    logic                    pop;
    logic                    accept;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_last;

    assign m_write      = 1'b0;
    assign m_byteenable = BYTEEN_ALL;
    assign m_clken      = 1'b1;

    assign len_ext   = {1'b0, len_q};
    assign accept    = cmd_valid & cmd_ready;
    assign push      = rd_pipe[READ_LATENCY-1];
    assign push_last = ((rcvd + (LEN_W+1)'(1)) == len_ext);
    assign out_valid = ~fifo_empty;
    assign out_last  = out_valid & fifo_last;
    assign pop       = out_valid & out_ready;

    // Every read in flight already owns a FIFO slot, so returns never drop
    always_comb begin
        occupancy = 32'(fifo_count) + 32'(m_chipselect);
        for (int i = 0; i < READ_LATENCY; i++)
            occupancy = occupancy + 32'(rd_pipe[i]);
    end

    assign can_issue = (state == ISSUE) && (issued < len_ext) &&
                       (occupancy < 32'(FIFO_DEPTH)) && !fifo_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            base_q       <= '0;
            len_q        <= '0;
            issued       <= '0;
            popped       <= '0;
            rcvd         <= '0;
            m_chipselect <= 1'b0;
            m_address    <= '0;
            rd_pipe      <= '0;
        end else begin
            m_chipselect <= can_issue;
            rd_pipe[0]   <= m_chipselect;
            for (int i = 1; i < READ_LATENCY; i++)
                rd_pipe[i] <= rd_pipe[i-1];
            if (can_issue) begin
                m_address <= base_q + ADDR_W'(issued);
                issued    <= issued + (LEN_W+1)'(1);
            end
            if (push)
                rcvd <= rcvd + (LEN_W+1)'(1);
            if (pop)
                popped <= popped + (LEN_W+1)'(1);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        base_q    <= cmd_base;
                        len_q     <= cmd_len;
                        issued    <= '0;
                        popped    <= '0;
                        rcvd      <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issued == len_ext)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (popped == len_ext) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({push_last, m_readdata}),
        .pop       (pop),
        .pop_data  ({fifo_last, out_data}),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef AVMM_READ_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            csum_q <= '0;
        else if (accept)
            csum_q <= '0;
        else if (pop)
            csum_q <= csum_q + out_data;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_avmm_block_read_master.sv
// Scoreboard bench for avmm_block_read_master with a 1-cycle-latency RAM model.
module tb_avmm_block_read_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_base;
    logic [15:0] cmd_len;
    logic        busy;
    logic        done;
    logic [15:0] m_address;
    logic        m_chipselect;
    logic        m_write;
    logic [3:0]  m_byteenable;
    logic        m_clken;
    logic [31:0] m_readdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic [31:0] checksum;

    logic [31:0] mem [0:65535];
    logic [32:0] exp_q [$];
    logic [32:0] obs_q [$];
    logic [15:0] addr_q [$];
    int          cyc_q [$];
    int          cyc;
    int          cs_cnt;
    int          done_cnt;
    logic [31:0] done_csum;
    int          pass_cnt;
    int          total_cnt;

    always #5 clk = ~clk;

    avmm_block_read_master dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_base     (cmd_base),
        .cmd_len      (cmd_len),
        .busy         (busy),
        .done         (done),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_byteenable (m_byteenable),
        .m_clken      (m_clken),
        .m_readdata   (m_readdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .checksum     (checksum)
    );

    // Synchronous RAM: address sampled at the edge, data valid the next cycle
    always @(posedge clk) begin
        if (m_chipselect)
            m_readdata <= mem[m_address];
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (m_chipselect) begin
                addr_q.push_back(m_address);
                cyc_q.push_back(cyc);
                cs_cnt = cs_cnt + 1;
            end
            if (out_valid && out_ready)
                obs_q.push_back({out_last, out_data});
            if (done) begin
                done_cnt  = done_cnt + 1;
                done_csum = checksum;
            end
        end
    end

    task automatic send_cmd(input logic [15:0] base, input logic [15:0] len,
                            input bit push_exp);
        logic [15:0] a;
        @(posedge clk);
        #1;
        cmd_base  = base;
        cmd_len   = len;
        cmd_valid = 1'b1;
        if (push_exp) begin
            for (int i = 0; i < int'(len); i++) begin
                a = base + 16'(i);
                exp_q.push_back({(i == int'(len) - 1), mem[a]});
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({cmd_ready, busy, done, m_chipselect} !== 4'b1000)
            $display("FAIL reset_ctrl got %b want 1000",
                     {cmd_ready, busy, done, m_chipselect});
        else pass_cnt++;
        total_cnt++;
        if ({m_address, out_valid, out_last} !== 18'h0)
            $display("FAIL reset_out got %h want 0",
                     {m_address, out_valid, out_last});
        else pass_cnt++;
        total_cnt++;
        if (checksum !== 32'h0)
            $display("FAIL reset_csum got %h want 0", checksum);
        else pass_cnt++;
        total_cnt++;
        if ({m_write, m_byteenable, m_clken} !== 6'b0_1111_1)
            $display("FAIL consts got %b want 011111",
                     {m_write, m_byteenable, m_clken});
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int a0, d0;
        logic [32:0] e, o;
        for (int i = 0; i < 4; i++)
            mem[16'h0010 + 16'(i)] = 32'hA0 + 32'(i);
        out_ready = 1'b1;
        a0 = addr_q.size();
        d0 = done_cnt;
        send_cmd(16'h0010, 16'd4, 1'b1);
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        total_cnt++;
        if (done_cnt - d0 != 1)
            $display("FAIL basic_done got %0d pulses want 1", done_cnt - d0);
        else pass_cnt++;
        total_cnt++;
        if (addr_q.size() - a0 != 4)
            $display("FAIL basic_nreads got %0d want 4", addr_q.size() - a0);
        else begin
            pass_cnt++;
            for (int i = 0; i < 4; i++) begin
                total_cnt++;
                if (addr_q[a0+i] !== 16'h0010 + 16'(i))
                    $display("FAIL basic_addr%0d got %h want %h", i,
                             addr_q[a0+i], 16'h0010 + 16'(i));
                else pass_cnt++;
            end
            total_cnt++;
            if (cyc_q[a0+3] - cyc_q[a0] != 3)
                $display("FAIL basic_consec got span %0d want 3",
                         cyc_q[a0+3] - cyc_q[a0]);
            else pass_cnt++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0)
                $display("FAIL basic_stream got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL basic_stream got %h want %h", o, e);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs_q.size() != 0)
            $display("FAIL basic_extra got %0d extra words want 0", obs_q.size());
        else pass_cnt++;
    endtask

    task automatic test_len_zero();
        int c0, o0;
        c0 = cs_cnt;
        o0 = obs_q.size();
        @(posedge clk);
        #1;
        cmd_base  = 16'h0055;
        cmd_len   = 16'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b1) $display("FAIL len0_done got %b want 1", done);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0) $display("FAIL len0_pulse got %b want 0", done);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (cs_cnt != c0 || obs_q.size() != o0)
            $display("FAIL len0_quiet got reads %0d words %0d want 0 0",
                     cs_cnt - c0, obs_q.size() - o0);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int a0, d0;
        logic [15:0] a;
        logic [32:0] e, o;
        for (int i = 0; i < 4; i++) begin
            a = 16'hFFFE + 16'(i);
            mem[a] = 32'hC0DE_0000 + 32'(i);
        end
        a0 = addr_q.size();
        d0 = done_cnt;
        send_cmd(16'hFFFE, 16'd4, 1'b1);
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
        total_cnt++;
        if (done_cnt == d0) $display("FAIL wrap_timeout got no done want done");
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            a = 16'hFFFE + 16'(i);
            total_cnt++;
            if (addr_q.size() <= a0 + i)
                $display("FAIL wrap_addr%0d got none want %h", i, a);
            else if (addr_q[a0+i] !== a)
                $display("FAIL wrap_addr%0d got %h want %h", i, addr_q[a0+i], a);
            else pass_cnt++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0)
                $display("FAIL wrap_stream got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL wrap_stream got %h want %h", o, e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_backpressure();
        int c0, d0;
        logic [32:0] e, o;
        for (int i = 0; i < 20; i++)
            mem[16'h0100 + 16'(i)] = $urandom;
        out_ready = 1'b0;
        c0 = cs_cnt;
        d0 = done_cnt;
        send_cmd(16'h0100, 16'd20, 1'b1);
        repeat (5) @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== mem[16'h0100])
            $display("FAIL bp_head got %b %h want 1 %h",
                     out_valid, out_data, mem[16'h0100]);
        else pass_cnt++;
        repeat (25) @(negedge clk);
        total_cnt++;
        if (cs_cnt - c0 != 8)
            $display("FAIL bp_credit got %0d reads want 8", cs_cnt - c0);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== mem[16'h0100] || out_last !== 1'b0)
            $display("FAIL bp_hold got %h %b want %h 0",
                     out_data, out_last, mem[16'h0100]);
        else pass_cnt++;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
        total_cnt++;
        if (cs_cnt - c0 != 20)
            $display("FAIL bp_reads got %0d want 20", cs_cnt - c0);
        else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0)
                $display("FAIL bp_stream got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL bp_stream got %h want %h", o, e);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (obs_q.size() != 0)
            $display("FAIL bp_extra got %0d extra words want 0", obs_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int d0;
        logic [32:0] e, o;
        for (int i = 0; i < 10; i++)
            mem[16'h0200 + 16'(i)] = 32'h2000_0000 + 32'(i);
        mem[16'h0300] = 32'h3333_0001;
        mem[16'h0301] = 32'h3333_0002;
        out_ready = 1'b0;
        send_cmd(16'h0200, 16'd10, 1'b0);
        repeat (4) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1 || out_valid !== 1'b1)
            $display("FAIL mid_busy got %b %b want 1 1", busy, out_valid);
        else pass_cnt++;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({cmd_ready, busy, done, m_chipselect, out_valid, out_last} !== 6'b100000
            || m_address !== 16'h0)
            $display("FAIL mid_reset got %b addr %h want 100000 addr 0",
                     {cmd_ready, busy, done, m_chipselect, out_valid, out_last},
                     m_address);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (done_cnt != d0 || out_valid !== 1'b0)
            $display("FAIL mid_quiet got done %0d valid %b want 0 0",
                     done_cnt - d0, out_valid);
        else pass_cnt++;
        send_cmd(16'h0300, 16'd2, 1'b1);
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
        total_cnt++;
        if (done_cnt - d0 != 1)
            $display("FAIL mid_done got %0d want 1", done_cnt - d0);
        else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0)
                $display("FAIL mid_stream got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL mid_stream got %h want %h", o, e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_checksum();
        int d0;
        logic [31:0] want;
        logic [32:0] e, o;
        mem[16'h0400] = 32'h0000_0001;
        mem[16'h0401] = 32'h0000_0002;
        mem[16'h0402] = 32'hFFFF_FFFF;
`ifdef AVMM_READ_CHECKSUM_EN
        want = 32'h0000_0002;
`else
        want = 32'h0000_0000;
`endif
        d0 = done_cnt;
        send_cmd(16'h0400, 16'd3, 1'b1);
        for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
        total_cnt++;
        if (done_cnt == d0 || done_csum !== want)
            $display("FAIL csum_done got %h want %h", done_csum, want);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (checksum !== want)
            $display("FAIL csum_hold got %h want %h", checksum, want);
        else pass_cnt++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (obs_q.size() == 0)
                $display("FAIL csum_stream got none want %h", e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL csum_stream got %h want %h", o, e);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        cyc       = 0;
        cs_cnt    = 0;
        done_cnt  = 0;
        done_csum = '0;
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_checksum();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
